// File: rtl/aes_wb_bridge.sv
// aes_wb_bridge
// Registered Wishbone bridge from the network adapter master port to the AES
// core slave port. Accesses outside the configured address window are
// rejected with an error, legal accesses are forwarded one at a time, and a
// downstream access that is not answered within TIMEOUT strobe cycles is
// terminated with an error so the upstream master can never hang.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   wbs_*             upstream Wishbone slave side (from network adapter)
//   wbm_*             downstream Wishbone master side (to AES core)
//   busy_o            high whenever the FSM is not IDLE
//   timeout_cnt_o     saturating count of timed-out accesses since reset
//
// State | meaning
// IDLE  | waiting for an upstream cyc & stb
// REQ   | downstream strobe active, waiting for ack/err/timeout/abort
// RESP  | one-cycle upstream ack or err with wbs_dat_o valid

module aes_wb_bridge #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
    parameter logic [15:0] TIMEOUT   = 16'd255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] wbs_dat_o,

    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i,

    output logic        busy_o,
    output logic [7:0]  timeout_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Counts strobe cycles of the current downstream access, starting at 1 in
    // the first REQ cycle, so the compare against TIMEOUT needs no offset.
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nxt;

    logic [31:0] wbm_adr_nxt;
    logic [31:0] wbm_dat_nxt;
    logic [3:0]  wbm_sel_nxt;
    logic        wbm_we_nxt;
    logic        wbm_cyc_nxt;
    logic        wbs_ack_nxt;
    logic        wbs_err_nxt;
    logic [31:0] wbs_dat_nxt;
    logic        busy_nxt;
    logic [7:0]  timeout_cnt_nxt;

    logic        in_window;

    assign in_window = ((wbs_adr_i & ADDR_MASK) == ADDR_BASE);

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        wbm_adr_nxt     = wbm_adr_o;
        wbm_dat_nxt     = wbm_dat_o;
        wbm_sel_nxt     = wbm_sel_o;
        wbm_we_nxt      = wbm_we_o;
        wbs_ack_nxt     = 1'b0;
        wbs_err_nxt     = 1'b0;
        wbs_dat_nxt     = wbs_dat_o;
        timeout_cnt_nxt = timeout_cnt_o;

        case (state)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (in_window) begin
                        wbm_adr_nxt  = wbs_adr_i;
                        wbm_dat_nxt  = wbs_dat_i;
                        wbm_sel_nxt  = wbs_sel_i;
                        wbm_we_nxt   = wbs_we_i;
                        wait_cnt_nxt = 16'd1;
                        state_nxt    = REQ;
                    end else begin
                        wbs_err_nxt = 1'b1;
                        wbs_dat_nxt = 32'h0;
                        state_nxt   = RESP;
                    end
                end
            end

            REQ: begin
                // Abort beats any downstream answer: the upstream master has
                // walked away, so nothing may be returned to it.
                if (!wbs_cyc_i) begin
                    state_nxt = IDLE;
                end else if (wbm_err_i) begin
                    wbs_err_nxt = 1'b1;
                    wbs_dat_nxt = 32'h0;
                    state_nxt   = RESP;
                end else if (wbm_ack_i) begin
                    wbs_ack_nxt = 1'b1;
                    wbs_dat_nxt = wbm_we_o ? 32'h0 : wbm_dat_i;
                    state_nxt   = RESP;
                end else if (wait_cnt == TIMEOUT) begin
                    wbs_err_nxt = 1'b1;
                    wbs_dat_nxt = 32'h0;
                    if (timeout_cnt_o != 8'hFF) begin
                        timeout_cnt_nxt = timeout_cnt_o + 8'd1;
                    end
                    state_nxt = RESP;
                end else begin
                    // wait_cnt < TIMEOUT <= 65535 here, so this cannot wrap.
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        wbm_cyc_nxt = (state_nxt == REQ);
        busy_nxt    = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= 16'h0;
            wbm_adr_o     <= 32'h0;
            wbm_dat_o     <= 32'h0;
            wbm_sel_o     <= 4'h0;
            wbm_we_o      <= 1'b0;
            wbm_cyc_o     <= 1'b0;
            wbm_stb_o     <= 1'b0;
            wbs_ack_o     <= 1'b0;
            wbs_err_o     <= 1'b0;
            wbs_dat_o     <= 32'h0;
            busy_o        <= 1'b0;
            timeout_cnt_o <= 8'h0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_cnt_nxt;
            wbm_adr_o     <= wbm_adr_nxt;
            wbm_dat_o     <= wbm_dat_nxt;
            wbm_sel_o     <= wbm_sel_nxt;
            wbm_we_o      <= wbm_we_nxt;
            wbm_cyc_o     <= wbm_cyc_nxt;
            wbm_stb_o     <= wbm_cyc_nxt;
            wbs_ack_o     <= wbs_ack_nxt;
            wbs_err_o     <= wbs_err_nxt;
            wbs_dat_o     <= wbs_dat_nxt;
            busy_o        <= busy_nxt;
            timeout_cnt_o <= timeout_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_aes_wb_bridge.sv
// Directed bench for aes_wb_bridge with TIMEOUT = 8. Inputs are driven and
// outputs sampled 1 time unit after each rising edge; "cycle n" is the
// interval following the n-th edge counted from the start of an access.

module tb_aes_wb_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic [31:0] wbm_dat_i;
    logic        busy_o;
    logic [7:0]  timeout_cnt_o;

    int checks = 0;
    int errors = 0;

    aes_wb_bridge #(
        .ADDR_BASE(32'h0000_0000),
        .ADDR_MASK(32'hFFFF_FF00),
        .TIMEOUT  (16'd8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wbs_adr_i    (wbs_adr_i),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_sel_i    (wbs_sel_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_ack_o    (wbs_ack_o),
        .wbs_err_o    (wbs_err_o),
        .wbs_dat_o    (wbs_dat_o),
        .wbm_adr_o    (wbm_adr_o),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_sel_o    (wbm_sel_o),
        .wbm_we_o     (wbm_we_o),
        .wbm_cyc_o    (wbm_cyc_o),
        .wbm_stb_o    (wbm_stb_o),
        .wbm_ack_i    (wbm_ack_i),
        .wbm_err_i    (wbm_err_i),
        .wbm_dat_i    (wbm_dat_i),
        .busy_o       (busy_o),
        .timeout_cnt_o(timeout_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic we);
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        wbs_we_i  = we;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
    endtask

    task automatic drop_req();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({wbs_ack_o, wbs_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ack=%b err=%b cyc=%b stb=%b we=%b busy=%b want all 0",
                     wbs_ack_o, wbs_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o);
        end
        checks++;
        if ({wbs_dat_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, timeout_cnt_o} !== 108'h0) begin
            errors++;
            $display("FAIL reset_data got dat_o=%h adr=%h wdat=%h sel=%h tcnt=%0d want all 0",
                     wbs_dat_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, timeout_cnt_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read();
        drive_req(32'h10, 32'h0, 4'hF, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 3) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'hCAFEF00D;
            end
            checks++;
            if (wbm_stb_o !== 1'b1 || wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h10 || wbm_we_o !== 1'b0) begin
                errors++;
                $display("FAIL read_req cycle %0d got stb=%b cyc=%b adr=%h we=%b want 1 1 00000010 0",
                         c, wbm_stb_o, wbm_cyc_o, wbm_adr_o, wbm_we_o);
            end
        end
        step();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        checks++;
        if (wbs_ack_o !== 1'b1 || wbs_err_o !== 1'b0 || wbs_dat_o !== 32'hCAFEF00D || wbm_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL read_resp cycle 4 got ack=%b err=%b dat=%h stb=%b want 1 0 cafef00d 0",
                     wbs_ack_o, wbs_err_o, wbs_dat_o, wbm_stb_o);
        end
        step();
        drop_req();
        checks++;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'hCAFEF00D || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL read_after got ack=%b dat=%h busy=%b want 0 cafef00d 0",
                     wbs_ack_o, wbs_dat_o, busy_o);
        end
        step();
    endtask

    // Write acked immediately, then a read presented in cycle k+2 (cycle 3).
    task automatic test_write_back_to_back();
        drive_req(32'h04, 32'hDEADBEEF, 4'hF, 1'b1);
        step();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h12345678;
        checks++;
        if (wbm_dat_o !== 32'hDEADBEEF || wbm_we_o !== 1'b1 || wbm_sel_o !== 4'hF ||
            wbm_adr_o !== 32'h04 || wbm_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL write_req got wdat=%h we=%b sel=%h adr=%h stb=%b want deadbeef 1 f 00000004 1",
                     wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_stb_o);
        end
        step();
        wbm_ack_i = 1'b0;
        checks++;
        if (wbs_ack_o !== 1'b1 || wbs_err_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL write_resp got ack=%b err=%b dat=%h want 1 0 00000000",
                     wbs_ack_o, wbs_err_o, wbs_dat_o);
        end
        step();
        drive_req(32'h20, 32'h0, 4'h3, 1'b0);
        step();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0BADC0DE;
        checks++;
        if (wbm_stb_o !== 1'b1 || wbm_adr_o !== 32'h20 || wbm_we_o !== 1'b0 || wbm_sel_o !== 4'h3) begin
            errors++;
            $display("FAIL b2b_req got stb=%b adr=%h we=%b sel=%h want 1 00000020 0 3",
                     wbm_stb_o, wbm_adr_o, wbm_we_o, wbm_sel_o);
        end
        step();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        checks++;
        if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h0BADC0DE) begin
            errors++;
            $display("FAIL b2b_resp got ack=%b dat=%h want 1 0badc0de", wbs_ack_o, wbs_dat_o);
        end
        step();
        drop_req();
        step();
    endtask

    task automatic test_out_of_window();
        drive_req(32'h100, 32'h0, 4'hF, 1'b0);
        step();
        checks++;
        if (wbs_err_o !== 1'b1 || wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || wbm_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL oow_resp got err=%b ack=%b dat=%h cyc=%b want 1 0 00000000 0",
                     wbs_err_o, wbs_ack_o, wbs_dat_o, wbm_cyc_o);
        end
        step();
        drop_req();
        checks++;
        if (wbs_err_o !== 1'b0 || wbm_cyc_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL oow_after got err=%b cyc=%b busy=%b want 0 0 0", wbs_err_o, wbm_cyc_o, busy_o);
        end
        step();
    endtask

    task automatic test_timeout();
        int stb_cycles;
        stb_cycles = 0;
        drive_req(32'h08, 32'h0, 4'hF, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (wbm_stb_o === 1'b1 && wbs_err_o === 1'b0) stb_cycles++;
        end
        checks++;
        if (stb_cycles != 8) begin
            errors++;
            $display("FAIL timeout_stb got %0d strobe cycles want 8", stb_cycles);
        end
        step();
        checks++;
        if (wbs_err_o !== 1'b1 || wbs_ack_o !== 1'b0 || wbm_stb_o !== 1'b0 || timeout_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL timeout_resp cycle 9 got err=%b ack=%b stb=%b tcnt=%0d want 1 0 0 1",
                     wbs_err_o, wbs_ack_o, wbm_stb_o, timeout_cnt_o);
        end
        step();
        drop_req();
        step();
    endtask

    task automatic test_ack_at_timeout();
        drive_req(32'h0C, 32'h0, 4'hF, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 8) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'h5A5A0008;
            end
        end
        step();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        checks++;
        if (wbs_ack_o !== 1'b1 || wbs_err_o !== 1'b0 || wbs_dat_o !== 32'h5A5A0008 || timeout_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL ack_at_timeout got ack=%b err=%b dat=%h tcnt=%0d want 1 0 5a5a0008 1",
                     wbs_ack_o, wbs_err_o, wbs_dat_o, timeout_cnt_o);
        end
        step();
        drop_req();
        step();
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 300; n++) begin
            drive_req(32'h08, 32'h0, 4'hF, 1'b0);
            for (int c = 1; c <= 9; c++) step();
            step();
            drop_req();
            step();
        end
        checks++;
        if (timeout_cnt_o !== 8'd255) begin
            errors++;
            $display("FAIL saturation got tcnt=%0d want 255", timeout_cnt_o);
        end
    endtask

    task automatic test_err_priority();
        drive_req(32'h0C, 32'h0, 4'hF, 1'b0);
        step();
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        wbm_dat_i = 32'hFFFFFFFF;
        step();
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'h0;
        checks++;
        if (wbs_err_o !== 1'b1 || wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL err_priority got err=%b ack=%b dat=%h want 1 0 00000000",
                     wbs_err_o, wbs_ack_o, wbs_dat_o);
        end
        step();
        drop_req();
        step();
    endtask

    task automatic test_abort();
        drive_req(32'h14, 32'h0, 4'hF, 1'b0);
        step();
        checks++;
        if (wbm_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_req got cyc=%b want 1", wbm_cyc_o);
        end
        step();
        drop_req();
        step();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h77777777;
        checks++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbs_ack_o !== 1'b0 || wbs_err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_cycle3 got cyc=%b stb=%b ack=%b err=%b busy=%b want all 0",
                     wbm_cyc_o, wbm_stb_o, wbs_ack_o, wbs_err_o, busy_o);
        end
        step();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        checks++;
        if (wbs_ack_o !== 1'b0 || wbs_err_o !== 1'b0 || busy_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_late_ack got ack=%b err=%b busy=%b cyc=%b want all 0",
                     wbs_ack_o, wbs_err_o, busy_o, wbm_cyc_o);
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        drive_req(32'h18, 32'hA5A5A5A5, 4'h6, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drop_req();
        checks++;
        if ({wbs_ack_o, wbs_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o} !== 6'b0 ||
            {wbs_dat_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, timeout_cnt_o} !== 108'h0) begin
            errors++;
            $display("FAIL reset_mid got ack=%b err=%b cyc=%b stb=%b we=%b busy=%b adr=%h wdat=%h sel=%h tcnt=%0d want all 0",
                     wbs_ack_o, wbs_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o,
                     wbm_adr_o, wbm_dat_o, wbm_sel_o, timeout_cnt_o);
        end
        step();
        drive_req(32'h1C, 32'h0, 4'hF, 1'b0);
        step();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h13579BDF;
        checks++;
        if (wbm_stb_o !== 1'b1 || wbm_adr_o !== 32'h1C) begin
            errors++;
            $display("FAIL post_reset_req got stb=%b adr=%h want 1 0000001c", wbm_stb_o, wbm_adr_o);
        end
        step();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        checks++;
        if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h13579BDF) begin
            errors++;
            $display("FAIL post_reset_resp got ack=%b dat=%h want 1 13579bdf", wbs_ack_o, wbs_dat_o);
        end
        step();
        drop_req();
        step();
    endtask

    initial begin
        rst       = 1'b1;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;
        wbs_sel_i = 4'h0;
        wbs_we_i  = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'h0;

        test_reset();
        test_read();
        test_write_back_to_back();
        test_out_of_window();
        test_timeout();
        test_ack_at_timeout();
        test_err_priority();
        test_abort();
        test_saturation();
        test_reset_mid_access();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
